// File: rtl/rv32i_inst_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32i_inst_encoder_if
// Request/response stream bundle for the RV32I instruction encoder.
//   Request side : in_valid/in_ready handshake carrying the decoded-style
//                  fields in_kind, in_alu_ctrl, in_branch, in_ls_type,
//                  in_rs1, in_rs2, in_rd, in_imm.
//   Response side: out_valid/out_ready handshake carrying out_inst, out_last
//                  and out_err.
// Modports:
//   master - the stimulus source and the word consumer (drives requests and
//            out_ready).
//   slave  - the encoder itself.
// ---------------------------------------------------------------------------
interface rv32i_inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_kind;
   logic [3:0]  in_alu_ctrl;
   logic [2:0]  in_branch;
   logic [3:0]  in_ls_type;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_last;
   logic        out_err;

   modport master (
      output in_valid, in_kind, in_alu_ctrl, in_branch, in_ls_type,
             in_rs1, in_rs2, in_rd, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_last, out_err
   );

   modport slave (
      input  in_valid, in_kind, in_alu_ctrl, in_branch, in_ls_type,
             in_rs1, in_rs2, in_rd, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_last, out_err
   );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_inst_encoder
// Packs decoded-style fields into 32-bit RV32I instruction words, one word
// per cycle, with LI expanded into LUI (+ ADDI when the low part is nonzero).
// Illegal requests come out as NOP_WORD with out_err set.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - rv32i_inst_encoder_if.slave: request stream in, word stream out
// Optional build macro:
//   ENC_IMM_CHECK_EN - when defined, out-of-range immediates are rejected
//                      (NOP_WORD, out_err=1) instead of being truncated.
// ---------------------------------------------------------------------------
module rv32i_inst_encoder #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   rv32i_inst_encoder_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EMIT2} state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LOAD = 4'd2, K_STORE = 4'd3,
                          K_BRANCH = 4'd4, K_JAL = 4'd5, K_JALR = 4'd6, K_LUI = 4'd7,
                          K_AUIPC = 4'd8, K_LI = 4'd9, K_NOP = 4'd10;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   state_t      r_state;
   logic        r_valid;
   logic        r_last;
   logic        r_err;
   logic [31:0] r_inst;
   logic [4:0]  r_pend_rd;   // rd of an LI whose ADDI is still owed
   logic [11:0] r_pend_lo;   // low 12 bits of that LI

   logic [31:0] w_imm;
   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic [3:0]  w_ls;
   logic [2:0]  w_br;
   logic [2:0]  w_alu_f3;
   logic [6:0]  w_alu_f7;
   logic        w_alu_ok;
   logic        w_is_shift;
   logic        w_fits12;
   logic [19:0] w_li_hi;
   logic [31:0] w_word;
   logic        w_code_bad;
   logic        w_imm_bad;
   logic        w_err;
   logic        w_last;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_out_fire;

   assign w_imm = bus.in_imm;
   assign w_rs1 = bus.in_rs1;
   assign w_rs2 = bus.in_rs2;
   assign w_rd  = bus.in_rd;
   assign w_ls  = bus.in_ls_type;
   assign w_br  = bus.in_branch;

   assign w_fits12 = (w_imm[31:11] == '0) | (w_imm[31:11] == '1);
   // (imm + 0x800)[31:12] without a 32-bit adder: the rounding carry only
   // ever enters at bit 12, and the sum wraps naturally at 20 bits.
   assign w_li_hi  = w_imm[31:12] + {19'd0, w_imm[11]};

   // ALU control -> funct3/funct7, shared by R and I formats.
   // NOTE: every signal written in an always_comb gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      w_alu_f3   = 3'b000;
      w_alu_f7   = 7'b0000000;
      w_alu_ok   = 1'b1;
      w_is_shift = 1'b0;
      case (bus.in_alu_ctrl)
         4'b0000: w_alu_f3 = 3'b000;
         4'b0001: w_alu_f7 = 7'b0100000;
         4'b0010: w_alu_f3 = 3'b111;
         4'b0011: w_alu_f3 = 3'b110;
         4'b0100: w_alu_f3 = 3'b100;
         4'b0101: begin w_alu_f3 = 3'b001; w_is_shift = 1'b1; end
         4'b0110: w_alu_f3 = 3'b010;
         4'b0111: w_alu_f3 = 3'b011;
         4'b1000: begin w_alu_f3 = 3'b101; w_is_shift = 1'b1; end
         4'b1001: begin w_alu_f3 = 3'b101; w_alu_f7 = 7'b0100000; w_is_shift = 1'b1; end
         default: w_alu_ok = 1'b0;
      endcase
   end

`ifdef ENC_IMM_CHECK_EN
   always_comb begin
      w_imm_bad = 1'b0;
      case (bus.in_kind)
         K_I:                     w_imm_bad = w_is_shift ? (w_imm[11:5] != 7'd0) : !w_fits12;
         K_LOAD, K_STORE, K_JALR: w_imm_bad = !w_fits12;
         K_BRANCH: w_imm_bad = !((w_imm[31:12] == '0) | (w_imm[31:12] == '1)) | w_imm[0];
         K_JAL:    w_imm_bad = !((w_imm[31:20] == '0) | (w_imm[31:20] == '1)) | w_imm[0];
         K_LUI, K_AUIPC:          w_imm_bad = (w_imm[11:0] != 12'd0);
         default:                 w_imm_bad = 1'b0;
      endcase
   end
`else
   assign w_imm_bad = 1'b0;
`endif

   // Word for the incoming request (first word for a two-word LI).
   always_comb begin
      w_word     = NOP_WORD;
      w_code_bad = 1'b0;
      w_last     = 1'b1;
      case (bus.in_kind)
         K_R: begin
            w_code_bad = !w_alu_ok;
            w_word     = {w_alu_f7, w_rs2, w_rs1, w_alu_f3, w_rd, OP_R};
         end
         K_I: begin
            w_code_bad = !w_alu_ok | (bus.in_alu_ctrl == ALU_SUB);
            if (w_is_shift) w_word = {w_alu_f7, w_imm[4:0], w_rs1, w_alu_f3, w_rd, OP_I};
            else            w_word = {w_imm[11:0], w_rs1, w_alu_f3, w_rd, OP_I};
         end
         K_LOAD: begin
            // Legal even codes map to funct3 {ls[3], ls[2:1]}; the rest are holes.
            w_code_bad = w_ls[0] | (w_ls[2:1] == 2'b11) | (w_ls[3] & w_ls[2]);
            w_word     = {w_imm[11:0], w_rs1, {w_ls[3], w_ls[2:1]}, w_rd, OP_LOAD};
         end
         K_STORE: begin
            w_code_bad = !w_ls[0] | w_ls[3] | (w_ls[2:1] == 2'b11);
            w_word     = {w_imm[11:5], w_rs2, w_rs1, {1'b0, w_ls[2:1]}, w_imm[4:0], OP_STORE};
         end
         K_BRANCH: begin
            w_code_bad = (w_br[2:1] == 2'b01);
            w_word     = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_br, w_imm[4:1], w_imm[11], OP_BRANCH};
         end
         K_JAL:   w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, OP_JAL};
         K_JALR:  w_word = {w_imm[11:0], w_rs1, 3'b000, w_rd, OP_JALR};
         K_LUI:   w_word = {w_imm[31:12], w_rd, OP_LUI};
         K_AUIPC: w_word = {w_imm[31:12], w_rd, OP_AUIPC};
         K_LI: begin
            if (w_fits12) begin
               w_word = {w_imm[11:0], 5'd0, 3'b000, w_rd, OP_I};
            end else begin
               w_word = {w_li_hi, w_rd, OP_LUI};
               w_last = (w_imm[11:0] == 12'd0);
            end
         end
         K_NOP:   w_word = NOP_WORD;
         default: w_code_bad = 1'b1;
      endcase
      w_err = w_code_bad | w_imm_bad;
      if (w_err) begin
         w_word = NOP_WORD;
         w_last = 1'b1;
      end
   end

   // A new request may only overlap the final word of the previous one.
   assign w_in_ready = (r_state == S_IDLE) |
                       ((r_state == S_EMIT) & bus.out_ready & r_last);
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_out_fire = r_valid & bus.out_ready;

   // NOTE: state registers use non-blocking assignments so every flop in
   // this block samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_valid   <= 1'b0;
         r_inst    <= 32'd0;
         r_last    <= 1'b0;
         r_err     <= 1'b0;
         r_pend_rd <= 5'd0;
         r_pend_lo <= 12'd0;
      end else if (w_accept) begin
         r_state   <= S_EMIT;
         r_valid   <= 1'b1;
         r_inst    <= w_word;
         r_last    <= w_last;
         r_err     <= w_err;
         r_pend_rd <= w_rd;
         r_pend_lo <= w_imm[11:0];
      end else if (w_out_fire) begin
         if ((r_state == S_EMIT) && !r_last) begin
            // LUI just left: follow with ADDI rd,rd,lo.
            r_state <= S_EMIT2;
            r_inst  <= {r_pend_lo, r_pend_rd, 3'b000, r_pend_rd, OP_I};
            r_last  <= 1'b1;
            r_err   <= 1'b0;
         end else begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_inst  = r_inst;
   assign bus.out_last  = r_last;
   assign bus.out_err   = r_err;

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
Sequential RV32I instruction encoder. It is the inverse of the decode stage: it takes decoded-style fields (ALU_ctrl, branch, ls_type, rs1/rs2/rd, imm) and packs them into 32-bit instruction words. It uses a valid/ready stream on both sides and expands the LI pseudo-op into LUI+ADDI. It drives the trace_test stimulus path that feeds instruction memory/decode, so round-trip decode checks are possible.

Parameters:
NOP_WORD, 32'h00000000, word emitted for kind NOP and for rejected requests; matches the pipeline NOP opcode 7'b0000000.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid&in_ready
in_kind  input  4  0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 LI, 10 NOP; others illegal
in_alu_ctrl  input  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SLT 0110, SLTU 0111, SRL 1000, SRA 1001
in_branch  input  3  funct3 code (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111); 010 illegal
in_ls_type  input  4  LB 0000, LH 0010, LW 0100, LBU 1000, LHU 1010, SB 0001, SH 0011, SW 0101
in_rs1, in_rs2, in_rd  input  5 each  register indices
in_imm  input  32  immediate: byte offset for B/J; upper value [31:12] for LUI/AUIPC; full value for LI
out_valid  output  1  word valid
out_ready  input  1  downstream accepts
out_inst  output  32  encoded word
out_last  output  1  final word of the current request
out_err  output  1  current word is a NOP substituted for a rejected request

Behaviour:
- FSM: IDLE, EMIT, EMIT2. Output register holds one word.
- in_ready = (state==IDLE) | (state==EMIT & out_ready & out_last).
- On acceptance, out_valid is 1 on the next cycle. Latency is 1 cycle. Back-to-back throughput is 1 word/cycle.
- While out_valid & !out_ready: out_inst, out_last and out_err hold stable.
- R: funct3/funct7 come from in_alu_ctrl. SUB and SRA use funct7 0100000; all other ops use 0.
- I: same mapping with opcode 0010011.
  - SLL/SRL/SRA encode shamt = imm[4:0], with imm[11:5] = funct7.
  - SUB is illegal.
- LOAD: opcode 0000011, ls_type[0] must be 0. funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- STORE: opcode 0100011, ls_type[0] must be 1. funct3: SB 000, SH 001, SW 010. imm split [11:5]/[4:0].
- BRANCH: B-format from imm[12:1].
- JAL: J-format from imm[20:1].
- JALR: I-format with funct3 000.
- LUI/AUIPC: imm[31:12] placed in [31:12].
- NOP: NOP_WORD, out_last=1.
- LI:
  - If imm is in [-2048,2047]: emit ADDI rd,x0,imm (single word).
  - Else hi = (imm+32'h800)[31:12] and lo = imm[11:0].
  - Emit LUI rd,hi. If lo≠0, go to EMIT2 and emit ADDI rd,rd,lo.
  - out_last is 1 only on the final word.
- Illegal kind, alu_ctrl or branch code, or ls_type/kind mismatch: emit NOP_WORD with out_err=1 and out_last=1.
- Unused register fields in the output word are 0.
- Arithmetic (LI hi) wraps modulo 2^32.
- Reset: state=IDLE, out_valid=0, out_inst=0, out_last=0, out_err=0, in_ready=1. Reset mid-LI discards the pending second word.

Optional Feature:
ENC_IMM_CHECK_EN
- Defined: range-check immediates and reject out-of-range requests as NOP_WORD with out_err=1. Ranges:
  - I/LOAD/STORE/JALR: signed 12-bit.
  - BRANCH: signed 13-bit, bit0=0.
  - JAL: signed 21-bit, bit0=0.
  - Shifts: imm[11:5] must be 0.
  - LUI/AUIPC: imm[11:0] must be 0.
- Undefined: excess bits are silently truncated and out_err only reports opcode/code illegality.

Test Plan:
- R ADD rd=3 rs1=1 rs2=2 -> out_inst 0x002081B3, out_last=1, out_valid one cycle after accept.
- LI rd=5 imm=0x12345FFF -> words 0x123462B7 (last=0) then 0xFFF28293 (last=1); in_ready=0 between the two words.
- LI rd=1 imm=0x00010000 -> single word 0x000100B7, last=1. Then LI rd=1 imm=-1 -> 0xFFF00093.
- BRANCH BEQ rs1=1 rs2=2 imm=8 -> 0x00208463. STORE SW rs1=1 rs2=2 imm=4 -> 0x0020A223. Hold out_ready=0 for 5 cycles -> out_inst stable, no new accept.
- Illegal: BRANCH with code 010 -> 0x00000000, out_err=1. With ENC_IMM_CHECK_EN: I ADD imm=0x800 -> 0x00000000, out_err=1; without the macro -> 0x80000013, out_err=0.
- Assert rst during the first LI word -> next cycle out_valid=0, in_ready=1, no ADDI emitted.
